instr_mem_loader: RTL and testbench

- Boot-time writer for instruction memory. It is the producer side of the interface that instr_fetch reads.
- Consumes a framed byte stream from the SPART receive path and assembles the bytes into 32-bit instruction words.
- Writes those words sequentially into instruction memory from address 0.
- Holds the CPU stalled via cpu_hold until the image has been loaded and its checksum verified.

---
 rtl/instr_mem_loader.sv | 160 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: takes a framed byte stream (24-bit word count,
// MSB-first words, XOR checksum), writes words from address 0, holds the CPU until verified.
module instr_mem_loader #(
  parameter int ADDR_W         = 22,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0] ERR_NONE = 2'b00, ERR_CSUM = 2'b01, ERR_TMO = 2'b10;

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d, words_q, words_d, addr_q, addr_d;
  logic [31:0]       word_q, word_d, wdata_q, wdata_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        bcnt_q, bcnt_d, err_q, err_d;
  logic [TW-1:0]     to_q, to_d;
  logic              hold_q, hold_d, done_q, done_d;
  logic              active, accept;

  assign active       = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign accept       = active && rx_valid;
  assign rx_ready     = active;
  assign imem_we      = (state_q == WRITE);
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_q;
    addr_d  = addr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    csum_d  = csum_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    to_d    = to_q;
    hold_d  = hold_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          n_d     = '0;
          words_d = '0;
          csum_d  = '0;
          bcnt_d  = '0;
          to_d    = '0;
          err_d   = ERR_NONE;
          done_d  = 1'b0;
          hold_d  = 1'b1;
        end
      end
      HDR: begin
        if (accept) begin
          // Shifting into an ADDR_W register keeps only the low bits of the 24-bit count.
          n_d    = {n_q[ADDR_W-9:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd2) begin
            bcnt_d  = '0;
            state_d = (n_d != '0) ? DATA : CSUM;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], rx_data};
          csum_d = csum_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = words_q;
            wdata_d = word_d;
          end
        end
      end
      WRITE: begin
        words_d = words_q + ADDR_W'(1);
        state_d = (words_d == n_q) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Idle-gap watchdog; any accepted byte restarts the window.
    if (accept) begin
      to_d = '0;
    end else if (active) begin
      if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERR;
        err_d   = ERR_TMO;
        hold_d  = 1'b1;
        to_d    = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      words_q <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= ERR_NONE;
      to_q    <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      csum_q  <= csum_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: good frame, bad checksum, empty image,
// timeout, back-to-back stream and mid-transfer reset.
module tb_instr_mem_loader;
  localparam int AW = 22;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, imem_we, cpu_hold, done;
  logic [AW-1:0] imem_addr, words_loaded;
  logic [31:0]   imem_wdata;
  logic [1:0]    err;

  instr_mem_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0]    fr[16];
  int            nb;
  int            stl[16];
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  always @(negedge clk) if (imem_we) begin
    wa.push_back(imem_addr);
    wd.push_back(imem_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte with rx_valid high; returns after the accepting edge (+1).
  task automatic send(input logic [7:0] b, output int stall);
    bit got = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    stall    = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rx_ready) begin got = 1; break; end
      stall++;
    end
    chk("byte_accepted", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_t1(input logic [7:0] cs);
    fr[0] = 8'h00; fr[1] = 8'h00; fr[2] = 8'h02;
    fr[3] = 8'hDE; fr[4] = 8'hAD; fr[5] = 8'hBE; fr[6]  = 8'hEF;
    fr[7] = 8'h01; fr[8] = 8'h23; fr[9] = 8'h45; fr[10] = 8'h67;
    fr[11] = cs;
    nb = 12;
  endtask

  task automatic run_frame(input bit gap, input bit chkw);
    int s;
    for (int i = 0; i < nb; i++) begin
      send(fr[i], s);
      stl[i] = s;
      if (chkw && (i == 6 || i == 10)) begin
        chk("we_after_4th", {31'd0, imem_we}, 32'd1);
        chk("we_addr", {10'd0, imem_addr}, (i == 6) ? 32'd0 : 32'd1);
        chk("we_data", imem_wdata, (i == 6) ? 32'hDEADBEEF : 32'h01234567);
        chk("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
        chk("hold_during_load", {31'd0, cpu_hold}, 32'd1);
      end
      if (gap) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic chk_writes(input int base, input string tag);
    chk({tag, "_wr_count"}, wa.size() - base, 32'd2);
    chk({tag, "_wr0_addr"}, {10'd0, wa[base]}, 32'd0);
    chk({tag, "_wr0_data"}, wd[base], 32'hDEADBEEF);
    chk({tag, "_wr1_addr"}, {10'd0, wa[base+1]}, 32'd1);
    chk({tag, "_wr1_data"}, wd[base+1], 32'h01234567);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, {10'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {30'd0, err}, 32'd0);
    chk({tag, "_words"}, {10'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    int base, s;
    // Reset state
    #3;
    chk_all_zero("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: good two-word frame with a one-cycle gap between bytes
    base = wa.size();
    pulse_start();
    chk("t1_hold_on_start", {31'd0, cpu_hold}, 32'd1);
    chk("t1_ready_in_hdr", {31'd0, rx_ready}, 32'd1);
    load_t1(8'h22);
    for (int i = 0; i < nb - 1; i++) begin
      send(fr[i], s);
      if (i == 6 || i == 10) begin
        chk("t1_we_after_4th", {31'd0, imem_we}, 32'd1);
        chk("t1_we_addr", {10'd0, imem_addr}, (i == 6) ? 32'd0 : 32'd1);
      end
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("t1_hold_before_csum", {31'd0, cpu_hold}, 32'd1);
    chk("t1_done_before_csum", {31'd0, done}, 32'd0);
    send(fr[nb-1], s);
    rx_valid = 1'b0;
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_err", {30'd0, err}, 32'd0);
    chk("t1_words", {10'd0, words_loaded}, 32'd2);
    chk("t1_hold_released", {31'd0, cpu_hold}, 32'd0);
    chk_writes(base, "t1");

    // Test 2: checksum mismatch
    base = wa.size();
    pulse_start();
    chk("t2_done_cleared", {31'd0, done}, 32'd0);
    load_t1(8'h23);
    run_frame(1'b0, 1'b1);
    chk_writes(base, "t2");
    chk("t2_err", {30'd0, err}, 32'd1);
    chk("t2_done", {31'd0, done}, 32'd0);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_err_sticky", {30'd0, err}, 32'd1);
    pulse_start();
    chk("t2_err_cleared", {30'd0, err}, 32'd0);

    // Test 3: empty image (already in HDR from the start above)
    base = wa.size();
    chk("t3_words_cleared", {10'd0, words_loaded}, 32'd0);
    fr[0] = 8'h00; fr[1] = 8'h00; fr[2] = 8'h00; fr[3] = 8'h00; nb = 4;
    run_frame(1'b0, 1'b0);
    chk("t3_no_write", wa.size() - base, 32'd0);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_words", {10'd0, words_loaded}, 32'd0);
    chk("t3_hold", {31'd0, cpu_hold}, 32'd0);

    // Test 4: timeout 16 cycles after the second header byte
    pulse_start();
    send(8'h00, s);
    send(8'h00, s);
    rx_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t4_err_before", {30'd0, err}, 32'd0);
    chk("t4_ready_before", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    chk("t4_err_timeout", {30'd0, err}, 32'd2);
    chk("t4_ready_after", {31'd0, rx_ready}, 32'd0);
    chk("t4_hold", {31'd0, cpu_hold}, 32'd1);

    // Test 5: back-to-back stream, rx_valid held high
    base = wa.size();
    pulse_start();
    load_t1(8'h22);
    run_frame(1'b0, 1'b1);
    for (int i = 0; i < 12; i++)
      chk($sformatf("t5_stall_%0d", i), stl[i], (i == 7 || i == 11) ? 32'd1 : 32'd0);
    chk_writes(base, "t5");
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_words", {10'd0, words_loaded}, 32'd2);

    // Test 6: reset in the middle of the second word
    pulse_start();
    load_t1(8'h22);
    for (int i = 0; i < 9; i++) send(fr[i], s);
    chk("t6_words_mid", {10'd0, words_loaded}, 32'd1);
    #2 rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk_all_zero("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = wa.size();
    pulse_start();
    run_frame(1'b0, 1'b1);
    chk_writes(base, "t6");
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_err", {30'd0, err}, 32'd0);
    chk("t6_words", {10'd0, words_loaded}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
